// File: rtl/sim_status_reporter.sv
// Simulation status producer: counts check results, emits sequenced report words,
// runs a watchdog and finishes with a summary word and sticky done/success flags.
module sim_status_reporter #(
   parameter int unsigned MIN_PASS       = 1,
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input  logic        refclk,
   input  logic        rst,
   input  logic        check_valid,
   output logic        check_ready,
   input  logic        check_pass,
   input  logic [15:0] check_code,
   input  logic        finish_req,
   output logic [31:0] sim_report,
   output logic        report_stb,
   output logic        sim_success,
   output logic        sim_done
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SUMMARY = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [3:0] KIND_PASS    = 4'd1;
   localparam logic [3:0] KIND_FAIL    = 4'd2;
   localparam logic [3:0] KIND_SUMMARY = 4'd3;
   localparam logic [3:0] KIND_TIMEOUT = 4'd4;

   state_t      state;
   logic [11:0] pass_cnt;
   logic [11:0] fail_cnt;
   logic [3:0]  seq;
   logic [31:0] wd;
   logic        timeout;

   logic        accept;
   logic        wd_hit;
   logic        pass_ok;
   logic [11:0] pass_inc;
   logic [11:0] fail_inc;

   assign check_ready = (state == RUN);
   assign accept      = check_valid & check_ready;

   always_comb begin
      wd_hit   = (TIMEOUT_CYCLES != 0) && (wd == TIMEOUT_CYCLES - 1);
      pass_ok  = (32'(pass_cnt) >= MIN_PASS);
      // counters stick at all-ones instead of wrapping
      pass_inc = (pass_cnt == '1) ? pass_cnt : pass_cnt + 12'd1;
      fail_inc = (fail_cnt == '1) ? fail_cnt : fail_cnt + 12'd1;
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= RUN;
         sim_report  <= '0;
         report_stb  <= 1'b0;
         sim_success <= 1'b0;
         sim_done    <= 1'b0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         seq         <= '0;
         wd          <= '0;
         timeout     <= 1'b0;
      end else begin
         report_stb <= 1'b0;
         case (state)
            RUN: begin
               wd <= wd + 32'd1;
               if (accept) begin
                  if (check_pass) pass_cnt <= pass_inc;
                  else            fail_cnt <= fail_inc;
                  sim_report <= {seq + 4'd1, check_pass ? KIND_PASS : KIND_FAIL,
                                 8'h00, check_code};
                  report_stb <= 1'b1;
                  seq        <= seq + 4'd1;
               end
               if (finish_req || wd_hit) begin
                  state   <= SUMMARY;
                  timeout <= wd_hit & ~finish_req;
               end
            end
            SUMMARY: begin
               sim_report <= {seq + 4'd1, timeout ? KIND_TIMEOUT : KIND_SUMMARY,
                              pass_cnt, fail_cnt};
               report_stb <= 1'b1;
               seq        <= seq + 4'd1;
               state      <= DONE;
            end
            DONE: begin
               if (!sim_done) begin
                  sim_done    <= 1'b1;
                  sim_success <= (fail_cnt == '0) && pass_ok && !timeout;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_sim_status_reporter.sv
// Directed bench for sim_status_reporter: default instance plus a short-watchdog instance.
module tb_sim_status_reporter;

   logic        refclk = 1'b0;
   logic        rst = 1'b1, rst2 = 1'b1;
   logic        check_valid = 1'b0, check_pass = 1'b0, finish_req = 1'b0;
   logic [15:0] check_code = '0;
   logic        check_ready, report_stb, sim_success, sim_done;
   logic [31:0] sim_report;
   logic        check_ready2, report_stb2, sim_success2, sim_done2;
   logic [31:0] sim_report2;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [3:0]  exp_seq  = '0;

   always #5 refclk = ~refclk;

   sim_status_reporter #(.MIN_PASS(1), .TIMEOUT_CYCLES(500000)) dut (
      .refclk(refclk), .rst(rst), .check_valid(check_valid), .check_ready(check_ready),
      .check_pass(check_pass), .check_code(check_code), .finish_req(finish_req),
      .sim_report(sim_report), .report_stb(report_stb), .sim_success(sim_success),
      .sim_done(sim_done));

   sim_status_reporter #(.MIN_PASS(1), .TIMEOUT_CYCLES(100)) dut_wd (
      .refclk(refclk), .rst(rst2), .check_valid(1'b0), .check_ready(check_ready2),
      .check_pass(1'b0), .check_code(16'h0000), .finish_req(1'b0),
      .sim_report(sim_report2), .report_stb(report_stb2), .sim_success(sim_success2),
      .sim_done(sim_done2));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [3:0] s, input logic [3:0] k,
                                        input logic [23:0] p);
      return {s, k, p};
   endfunction

   task automatic tick;
      @(posedge refclk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_seq = '0;
   endtask

   task automatic send(input logic pass, input logic [15:0] code, input logic chk);
      check_valid = 1'b1;
      check_pass  = pass;
      check_code  = code;
      tick();
      exp_seq = exp_seq + 4'd1;
      if (chk) begin
         check_val("check_word", sim_report,
                   word(exp_seq, pass ? 4'd1 : 4'd2, {8'h00, code}));
         check_val("check_stb", {31'd0, report_stb}, 32'd1);
      end
   endtask

   task automatic finish_seq(input logic [3:0] kind, input logic [11:0] p,
                             input logic [11:0] f, input logic succ);
      finish_req = 1'b1;
      tick();
      finish_req = 1'b0;
      check_val("summary_state_ready", {31'd0, check_ready}, 32'd0);
      check_val("summary_state_done", {31'd0, sim_done}, 32'd0);
      tick();
      exp_seq = exp_seq + 4'd1;
      check_val("summary_word", sim_report, word(exp_seq, kind, {p, f}));
      check_val("summary_stb", {31'd0, report_stb}, 32'd1);
      check_val("summary_not_done_yet", {31'd0, sim_done}, 32'd0);
      tick();
      check_val("done", {31'd0, sim_done}, 32'd1);
      check_val("success", {31'd0, sim_success}, {31'd0, succ});
      check_val("done_stb_low", {31'd0, report_stb}, 32'd0);
   endtask

   initial begin
      int unsigned stb_seen;
      int unsigned n;

      // reset held 4 cycles, then idle
      rst = 1'b1;
      repeat (4) tick();
      check_val("rst_report", sim_report, 32'h0);
      check_val("rst_flags", {28'd0, report_stb, sim_success, sim_done, check_ready}, 32'h1);
      rst = 1'b0;
      stb_seen = 0;
      repeat (10) begin
         tick();
         if (report_stb) stb_seen++;
      end
      check_val("idle_no_stb", stb_seen, 32'd0);

      // three back-to-back passes then finish
      send(1'b1, 16'h0001, 1'b1);
      check_val("word1", sim_report, 32'h11000001);
      send(1'b1, 16'h0002, 1'b1);
      check_val("word2", sim_report, 32'h21000002);
      send(1'b1, 16'h0003, 1'b1);
      check_val("word3", sim_report, 32'h31000003);
      check_valid = 1'b0;
      finish_seq(4'd3, 12'd3, 12'd0, 1'b1);
      check_val("summary_literal", sim_report, 32'h43003000);

      // pass + fail
      do_reset();
      send(1'b1, 16'hAAAA, 1'b1);
      check_val("pass_aaaa", sim_report, 32'h1100AAAA);
      send(1'b0, 16'hBEEF, 1'b1);
      check_val("fail_beef", sim_report, 32'h2200BEEF);
      check_valid = 1'b0;
      finish_seq(4'd3, 12'd1, 12'd1, 1'b0);
      check_val("summary_pf", sim_report, 32'h33001001);

      // accept on the same cycle as finish_req
      do_reset();
      check_valid = 1'b1; check_pass = 1'b1; check_code = 16'h0055; finish_req = 1'b1;
      tick();
      finish_req = 1'b0;
      check_val("sim_check_word", sim_report, 32'h11000055);
      check_val("sim_check_stb", {31'd0, report_stb}, 32'd1);
      check_val("sim_ready_low", {31'd0, check_ready}, 32'd0);
      tick();
      check_val("sim_summary", sim_report, 32'h23001000);
      check_val("sim_summary_stb", {31'd0, report_stb}, 32'd1);
      tick();
      check_val("sim_done", {31'd0, sim_done, sim_success}, 32'd3);
      check_code = 16'h7777;
      stb_seen = 0;
      repeat (5) begin
         tick();
         if (report_stb) stb_seen++;
      end
      check_val("done_ignores_checks", stb_seen, 32'd0);
      check_val("done_report_held", sim_report, 32'h23001000);
      check_val("done_sticky", {31'd0, sim_done}, 32'd1);
      check_valid = 1'b0;

      // MIN_PASS=1 with zero checks
      do_reset();
      finish_seq(4'd3, 12'd0, 12'd0, 1'b0);
      check_val("empty_summary", sim_report, 32'h13000000);

      // 17 reports: sequence wraps 15 -> 0, then reset while in SUMMARY
      do_reset();
      for (int i = 1; i <= 17; i++) send(1'b1, 16'(i), 1'b1);
      check_valid = 1'b0;
      check_val("wrap_word17", sim_report, 32'h11000011);
      finish_req = 1'b1;
      tick();
      finish_req = 1'b0;
      check_val("in_summary", {31'd0, check_ready}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rst_summary_report", sim_report, 32'h0);
      check_val("rst_summary_flags",
                {28'd0, report_stb, sim_success, sim_done, check_ready}, 32'h1);
      exp_seq = '0;
      send(1'b1, 16'h0042, 1'b1);
      check_val("run_resumed", sim_report, 32'h11000042);
      check_valid = 1'b0;

      // counter saturation: 4097 passes
      do_reset();
      for (int i = 0; i < 4097; i++) send(1'b1, 16'h0100, 1'b0);
      check_valid = 1'b0;
      check_val("sat_last_word", sim_report, word(exp_seq, 4'd1, 24'h000100));
      finish_seq(4'd3, 12'hFFF, 12'd0, 1'b1);

      // watchdog instance: timeout at 100 RUN cycles
      rst2 = 1'b1;
      tick();
      rst2 = 1'b0;
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (report_stb2) begin
            n = i;
            break;
         end
      end
      check_val("wd_latency", n, 32'd101);
      check_val("wd_summary", sim_report2, 32'h14000000);
      check_val("wd_not_done_yet", {31'd0, sim_done2}, 32'd0);
      tick();
      check_val("wd_done", {31'd0, sim_done2, sim_success2}, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
